slot_axil_regs: RTL and testbench
=================================

SLOT_AXIL_REGS -- requirements
Module: slot_axil_regs

Interface
REQ-001 Parameter BASE_ADDR, default 64'h0, byte address of register 0.
REQ-002 Parameter NUM_REGS, default 16, number of 64-bit registers (4..64).
REQ-003 Parameter ID_VALUE, default 64'h534C_4F54_0000_0001, constant returned by register 0.
REQ-004 sys_clk_clk_p  in  1  sole clock, all logic on rising edge.
REQ-005 sys_rst  in  1  synchronous, active-high reset.
REQ-006 SLOT_awaddr/awprot/awvalid  in  64/3/1, SLOT_awready  out  1  AXI4-Lite write address; awprot ignored.
REQ-007 SLOT_wdata/wstrb/wvalid  in  64/8/1, SLOT_wready  out  1  write data.
REQ-008 SLOT_bresp/bvalid  out  2/1, SLOT_bready  in  1  write response.
REQ-009 SLOT_araddr/arprot/arvalid  in  64/3/1, SLOT_arready  out  1  read address; arprot ignored.
REQ-010 SLOT_rdata/rresp/rvalid  out  64/2/1, SLOT_rready  in  1  read data.
REQ-011 status_in  in  64  device status, visible as register 1.
REQ-012 cfg_regs  out  NUM_REGS*64  flattened register contents, register i at bits [64i+63:64i].
REQ-013 wr_pulse  out  NUM_REGS  one-cycle strobe per register written.

Function
REQ-014 Decode: in range iff BASE_ADDR <= addr < BASE_ADDR+NUM_REGS*8; index = (addr-BASE_ADDR)>>3; addr[2:0] ignored.
REQ-015 Register 0 read-only ID_VALUE; register 1 read-only status_in; registers 2..NUM_REGS-1 read/write.
REQ-016 Write FSM states W_IDLE, W_RESP; AW and W captured independently in W_IDLE, either order or same cycle.
REQ-017 SLOT_awready=1 in W_IDLE until AW captured; SLOT_wready=1 in W_IDLE until W captured; both 0 in W_RESP.
REQ-018 Edge after both captured: byte-merge commit (byte k updated iff wstrb[k]), SLOT_bvalid<=1, wr_pulse[index]<=1 for one cycle, state W_RESP.
REQ-019 Write to read-only register: no storage change, wr_pulse still fires, bresp OKAY.
REQ-020 wstrb=8'h00: no byte changes, wr_pulse fires, bresp OKAY.
REQ-021 W_RESP: SLOT_bvalid and bresp held until SLOT_bready; on handshake bvalid<=0, captures cleared, return W_IDLE.
REQ-022 Read FSM states R_IDLE, R_DATA, independent of write FSM; SLOT_arready=1 only in R_IDLE.
REQ-023 AR handshake: SLOT_rdata<=full unshifted 64-bit word of indexed register, SLOT_rvalid<=1 next cycle, state R_DATA.
REQ-024 R_DATA: rdata/rresp/rvalid held until SLOT_rready; then rvalid<=0, R_IDLE; back-to-back read accepted no earlier than cycle after.
REQ-025 Same-edge AR handshake and write commit to same register: read returns pre-write value.
REQ-026 Single outstanding transaction per channel; no buffering beyond one AW, one W, one AR.
REQ-027 Out-of-range read data is 64'h0; out-of-range write changes nothing and raises no wr_pulse.

Reset
REQ-028 sys_rst high at an edge: both FSMs to idle, captures cleared, RW registers to 0, SLOT_bvalid/rvalid/wr_pulse 0, bresp/rresp 2'b00, rdata 0.
REQ-029 Reset mid-transaction abandons it silently; no response issued afterwards.
REQ-030 SLOT_awready, wready, arready 0 while sys_rst high, 1 first cycle after release.

Configuration
REQ-031 Macro SLOT_REGS_SLVERR_EN defined: out-of-range access gives bresp/rresp 2'b10 (SLVERR).
REQ-032 SLOT_REGS_SLVERR_EN undefined: out-of-range access gives 2'b00 (OKAY); data behaviour per REQ-027 unchanged.

Structure
REQ-033 Package slot_regs_pkg holds AXI resp constants (OKAY 2'b00, SLVERR 2'b10), FSM state enums, REG_ID=0, REG_STATUS=1.
REQ-034 One sub-module slot_addr_decode: address in, index and in_range out, combinational, parameterised by BASE_ADDR/NUM_REGS.

Verification
REQ-035 AW=BASE+0x10 and W=64'hDEAD_BEEF_0123_4567, strb 8'hFF same cycle -> bvalid next cycle OKAY, wr_pulse[2] one cycle, cfg_regs[2]=written value.
REQ-036 W before AW by 3 cycles, strb 8'h0F over 64'hFFFF_FFFF_FFFF_FFFF, data 64'h0 -> reg 2 = 64'hFFFF_FFFF_0000_0000.
REQ-037 Read BASE+0x0 and BASE+0x8 with status_in=64'h42 -> rdata ID_VALUE then 64'h42, OKAY; rready held low 5 cycles -> rvalid and rdata stable.
REQ-038 Read BASE+NUM_REGS*8 -> rdata 0, rresp 2'b10 with macro, 2'b00 without; write there -> no wr_pulse, no cfg_regs change.
REQ-039 Same-edge read and write commit to reg 3 (old 64'h1, new 64'h2) -> rdata 64'h1, then re-read returns 64'h2.
REQ-040 sys_rst asserted while bvalid pending -> bvalid 0, reg contents 0, next write completes normally.

Source files
------------

// File: rtl/slot_regs_pkg.sv
// Shared constants, FSM state types and the byte-merge helper for the SLOT register block.
package slot_regs_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam int REG_ID     = 0;
  localparam int REG_STATUS = 1;
  // Index width covers the largest supported register count (64).
  localparam int IDX_W      = 6;

  typedef enum logic {W_IDLE = 1'b0, W_RESP = 1'b1} w_state_e;
  typedef enum logic {R_IDLE = 1'b0, R_DATA = 1'b1} r_state_e;

  function automatic logic [63:0] byte_merge(input logic [63:0] old_v,
                                             input logic [63:0] new_v,
                                             input logic [7:0]  strb);
    logic [63:0] res;
    res = old_v;
    for (int k = 0; k < 8; k++) begin
      if (strb[k]) begin
        res[8*k +: 8] = new_v[8*k +: 8];
      end else begin
        res[8*k +: 8] = old_v[8*k +: 8];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/slot_addr_decode.sv
// Combinational byte-address to register-index decoder for the SLOT register window.
module slot_addr_decode
  import slot_regs_pkg::*;
#(
  parameter logic [63:0] BASE_ADDR = 64'h0,
  parameter int          NUM_REGS  = 16
) (
  input  logic [63:0]      addr,
  output logic [IDX_W-1:0] index,
  output logic             in_range
);

  localparam logic [63:0] SPAN = 64'(NUM_REGS) * 64'd8;

  logic [63:0] offset_s;

  // Offset from the window base; the lower bound check guards against wrap-around.
  always_comb begin
    offset_s = addr - BASE_ADDR;
    in_range = (addr >= BASE_ADDR) && (offset_s < SPAN);
    index    = offset_s[IDX_W+2:3];
  end

endmodule

// File: rtl/slot_axil_regs.sv
// AXI4-Lite slave with NUM_REGS 64-bit registers: ID, live status, then read/write registers.
// Define SLOT_REGS_SLVERR_EN to answer out-of-range accesses with SLVERR instead of OKAY.
module slot_axil_regs
  import slot_regs_pkg::*;
#(
  parameter logic [63:0] BASE_ADDR = 64'h0,
  parameter int          NUM_REGS  = 16,
  parameter logic [63:0] ID_VALUE  = 64'h534C_4F54_0000_0001
) (
  input  logic                     sys_clk_clk_p,
  input  logic                     sys_rst,
  input  logic [63:0]              SLOT_awaddr,
  input  logic [2:0]               SLOT_awprot,
  input  logic                     SLOT_awvalid,
  output logic                     SLOT_awready,
  input  logic [63:0]              SLOT_wdata,
  input  logic [7:0]               SLOT_wstrb,
  input  logic                     SLOT_wvalid,
  output logic                     SLOT_wready,
  output logic [1:0]               SLOT_bresp,
  output logic                     SLOT_bvalid,
  input  logic                     SLOT_bready,
  input  logic [63:0]              SLOT_araddr,
  input  logic [2:0]               SLOT_arprot,
  input  logic                     SLOT_arvalid,
  output logic                     SLOT_arready,
  output logic [63:0]              SLOT_rdata,
  output logic [1:0]               SLOT_rresp,
  output logic                     SLOT_rvalid,
  input  logic                     SLOT_rready,
  input  logic [63:0]              status_in,
  output logic [NUM_REGS*64-1:0]   cfg_regs,
  output logic [NUM_REGS-1:0]      wr_pulse
);

`ifdef SLOT_REGS_SLVERR_EN
  localparam logic [1:0] OOR_RESP = RESP_SLVERR;
`else
  localparam logic [1:0] OOR_RESP = RESP_OKAY;
`endif

  w_state_e             w_state_r;
  r_state_e             r_state_r;
  logic                 aw_done_r;
  logic                 w_done_r;
  logic [63:0]          awaddr_r;
  logic [63:0]          wdata_r;
  logic [7:0]           wstrb_r;
  logic                 bvalid_r;
  logic [1:0]           bresp_r;
  logic [NUM_REGS-1:0]  wr_pulse_r;
  logic                 rvalid_r;
  logic [1:0]           rresp_r;
  logic [63:0]          rdata_r;
  logic [63:0]          regs_r [2:NUM_REGS-1];
  logic [IDX_W-1:0]     w_index_s;
  logic                 w_in_range_s;
  logic [IDX_W-1:0]     r_index_s;
  logic                 r_in_range_s;
  logic [63:0]          rd_word_s;
  logic                 unused_s;

  assign unused_s = ^{SLOT_awprot, SLOT_arprot};

  slot_addr_decode #(.BASE_ADDR(BASE_ADDR), .NUM_REGS(NUM_REGS)) u_w_decode (
    .addr     (awaddr_r),
    .index    (w_index_s),
    .in_range (w_in_range_s)
  );

  slot_addr_decode #(.BASE_ADDR(BASE_ADDR), .NUM_REGS(NUM_REGS)) u_r_decode (
    .addr     (SLOT_araddr),
    .index    (r_index_s),
    .in_range (r_in_range_s)
  );

  // Ready lines follow registered state but are forced low while reset is held.
  assign SLOT_awready = !sys_rst && (w_state_r == W_IDLE) && !aw_done_r;
  assign SLOT_wready  = !sys_rst && (w_state_r == W_IDLE) && !w_done_r;
  assign SLOT_arready = !sys_rst && (r_state_r == R_IDLE);
  assign SLOT_bvalid  = bvalid_r;
  assign SLOT_bresp   = bresp_r;
  assign SLOT_rvalid  = rvalid_r;
  assign SLOT_rresp   = rresp_r;
  assign SLOT_rdata   = rdata_r;
  assign wr_pulse     = wr_pulse_r;

  // Flattened register view: ID and live status first, then the stored registers.
  always_comb begin
    cfg_regs = {(NUM_REGS*64){1'b0}};
    cfg_regs[64*REG_ID +: 64]     = ID_VALUE;
    cfg_regs[64*REG_STATUS +: 64] = status_in;
    for (int i = 2; i < NUM_REGS; i++) begin
      cfg_regs[64*i +: 64] = regs_r[i];
    end
  end

  // Read mux; out-of-range addresses select nothing and yield zero.
  always_comb begin
    rd_word_s = 64'd0;
    for (int i = 0; i < NUM_REGS; i++) begin
      rd_word_s = rd_word_s |
                  ((r_in_range_s && (r_index_s == IDX_W'(i))) ? cfg_regs[64*i +: 64] : 64'd0);
    end
  end

  // Write FSM: capture AW and W independently, commit on the following edge, hold B until taken.
  always_ff @(posedge sys_clk_clk_p) begin
    if (sys_rst) begin
      w_state_r  <= W_IDLE;
      aw_done_r  <= 1'b0;
      w_done_r   <= 1'b0;
      awaddr_r   <= 64'd0;
      wdata_r    <= 64'd0;
      wstrb_r    <= 8'd0;
      bvalid_r   <= 1'b0;
      bresp_r    <= RESP_OKAY;
      wr_pulse_r <= {NUM_REGS{1'b0}};
      for (int i = 2; i < NUM_REGS; i++) begin
        regs_r[i] <= 64'd0;
      end
    end else begin
      wr_pulse_r <= {NUM_REGS{1'b0}};
      case (w_state_r)
        W_IDLE: begin
          if (aw_done_r && w_done_r) begin
            if (w_in_range_s) begin
              for (int i = 2; i < NUM_REGS; i++) begin
                if (w_index_s == IDX_W'(i)) begin
                  regs_r[i] <= byte_merge(regs_r[i], wdata_r, wstrb_r);
                end
              end
              wr_pulse_r <= {{(NUM_REGS-1){1'b0}}, 1'b1} << w_index_s;
              bresp_r    <= RESP_OKAY;
            end else begin
              bresp_r    <= OOR_RESP;
            end
            bvalid_r  <= 1'b1;
            w_state_r <= W_RESP;
          end else begin
            if (SLOT_awvalid && SLOT_awready) begin
              aw_done_r <= 1'b1;
              awaddr_r  <= SLOT_awaddr;
            end
            if (SLOT_wvalid && SLOT_wready) begin
              w_done_r <= 1'b1;
              wdata_r  <= SLOT_wdata;
              wstrb_r  <= SLOT_wstrb;
            end
          end
        end
        W_RESP: begin
          if (SLOT_bready) begin
            bvalid_r  <= 1'b0;
            aw_done_r <= 1'b0;
            w_done_r  <= 1'b0;
            w_state_r <= W_IDLE;
          end
        end
        default: begin
          w_state_r <= W_IDLE;
        end
      endcase
    end
  end

  // Read FSM: sample the addressed word at the AR handshake and hold it until R is taken.
  always_ff @(posedge sys_clk_clk_p) begin
    if (sys_rst) begin
      r_state_r <= R_IDLE;
      rvalid_r  <= 1'b0;
      rresp_r   <= RESP_OKAY;
      rdata_r   <= 64'd0;
    end else begin
      case (r_state_r)
        R_IDLE: begin
          if (SLOT_arvalid) begin
            rdata_r   <= rd_word_s;
            rresp_r   <= r_in_range_s ? RESP_OKAY : OOR_RESP;
            rvalid_r  <= 1'b1;
            r_state_r <= R_DATA;
          end
        end
        R_DATA: begin
          if (SLOT_rready) begin
            rvalid_r  <= 1'b0;
            r_state_r <= R_IDLE;
          end
        end
        default: begin
          r_state_r <= R_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_slot_axil_regs.sv
// Randomised scoreboard bench for slot_axil_regs against a behavioural register-file model.
module tb_slot_axil_regs;

  localparam logic [63:0] BASE = 64'h0000_0000_4000_0000;
  localparam int          NR   = 16;
  localparam logic [63:0] IDV  = 64'h534C_4F54_0000_0001;
  localparam logic [63:0] STAT = 64'h0000_0000_0000_0042;
`ifdef SLOT_REGS_SLVERR_EN
  localparam logic [1:0] OOR = 2'b10;
`else
  localparam logic [1:0] OOR = 2'b00;
`endif

  typedef struct packed {
    logic [1:0]         resp;
    logic [NR-1:0]      mask;
    logic [NR*64-1:0]   cfg;
  } b_exp_t;

  typedef struct packed {
    logic [63:0] data;
    logic [1:0]  resp;
  } r_exp_t;

  logic              clk;
  logic              sys_rst;
  logic [63:0]       SLOT_awaddr;
  logic [2:0]        SLOT_awprot;
  logic              SLOT_awvalid;
  logic              SLOT_awready;
  logic [63:0]       SLOT_wdata;
  logic [7:0]        SLOT_wstrb;
  logic              SLOT_wvalid;
  logic              SLOT_wready;
  logic [1:0]        SLOT_bresp;
  logic              SLOT_bvalid;
  logic              SLOT_bready;
  logic [63:0]       SLOT_araddr;
  logic [2:0]        SLOT_arprot;
  logic              SLOT_arvalid;
  logic              SLOT_arready;
  logic [63:0]       SLOT_rdata;
  logic [1:0]        SLOT_rresp;
  logic              SLOT_rvalid;
  logic              SLOT_rready;
  logic [63:0]       status_in;
  logic [NR*64-1:0]  cfg_regs;
  logic [NR-1:0]     wr_pulse;

  int n_cmp = 0;
  int n_fail = 0;
  b_exp_t bq[$];
  r_exp_t rq[$];
  logic [63:0] mregs [NR];

  slot_axil_regs #(.BASE_ADDR(BASE), .NUM_REGS(NR), .ID_VALUE(IDV)) dut (
    .sys_clk_clk_p (clk),
    .sys_rst       (sys_rst),
    .SLOT_awaddr   (SLOT_awaddr),
    .SLOT_awprot   (SLOT_awprot),
    .SLOT_awvalid  (SLOT_awvalid),
    .SLOT_awready  (SLOT_awready),
    .SLOT_wdata    (SLOT_wdata),
    .SLOT_wstrb    (SLOT_wstrb),
    .SLOT_wvalid   (SLOT_wvalid),
    .SLOT_wready   (SLOT_wready),
    .SLOT_bresp    (SLOT_bresp),
    .SLOT_bvalid   (SLOT_bvalid),
    .SLOT_bready   (SLOT_bready),
    .SLOT_araddr   (SLOT_araddr),
    .SLOT_arprot   (SLOT_arprot),
    .SLOT_arvalid  (SLOT_arvalid),
    .SLOT_arready  (SLOT_arready),
    .SLOT_rdata    (SLOT_rdata),
    .SLOT_rresp    (SLOT_rresp),
    .SLOT_rvalid   (SLOT_rvalid),
    .SLOT_rready   (SLOT_rready),
    .status_in     (status_in),
    .cfg_regs      (cfg_regs),
    .wr_pulse      (wr_pulse)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded its time budget");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%h, expected 0x%h", nm, act, exp);
    end
  endtask

  // Reference model: plain address arithmetic over a register array.
  function automatic bit m_in_range(input logic [63:0] a);
    return (a >= BASE) && ((a - BASE) < 64'(NR * 8));
  endfunction

  function automatic int m_index(input logic [63:0] a);
    logic [63:0] off;
    off = (a - BASE) / 64'd8;
    return int'(off[15:0]);
  endfunction

  function automatic logic [63:0] m_read(input logic [63:0] a);
    int idx;
    if (!m_in_range(a)) return 64'd0;
    idx = m_index(a);
    if (idx == 0) return IDV;
    if (idx == 1) return STAT;
    return mregs[idx];
  endfunction

  function automatic logic [NR*64-1:0] m_cfg();
    logic [NR*64-1:0] v;
    for (int i = 0; i < NR; i++) begin
      v[64*i +: 64] = (i == 0) ? IDV : ((i == 1) ? STAT : mregs[i]);
    end
    return v;
  endfunction

  function automatic b_exp_t m_write(input logic [63:0] a, input logic [63:0] d, input logic [7:0] s);
    b_exp_t e;
    int idx;
    e.mask = '0;
    e.resp = OOR;
    if (m_in_range(a)) begin
      idx = m_index(a);
      e.resp = 2'b00;
      e.mask[idx] = 1'b1;
      if (idx >= 2) begin
        for (int k = 0; k < 8; k++) begin
          if (s[k]) mregs[idx][8*k +: 8] = d[8*k +: 8];
        end
      end
    end
    e.cfg = m_cfg();
    return e;
  endfunction

  task automatic send_aw(input logic [63:0] a);
    int n;
    SLOT_awaddr = a;
    SLOT_awvalid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!SLOT_awready && n < 50) begin
      n++;
      @(negedge clk);
    end
    chk("aw_accepted", 64'(SLOT_awready), 64'd1);
    @(posedge clk);
    #1 SLOT_awvalid = 1'b0;
  endtask

  task automatic send_w(input logic [63:0] d, input logic [7:0] s);
    int n;
    SLOT_wdata = d;
    SLOT_wstrb = s;
    SLOT_wvalid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!SLOT_wready && n < 50) begin
      n++;
      @(negedge clk);
    end
    chk("w_accepted", 64'(SLOT_wready), 64'd1);
    @(posedge clk);
    #1 SLOT_wvalid = 1'b0;
  endtask

  // mode 0: AW and W together; 1: AW leads W by gap; 2: W leads AW by gap. bdly < 0 leaves B pending.
  task automatic do_write(input logic [63:0] a, input logic [63:0] d, input logic [7:0] s,
                          input int mode, input int gap, input int bdly);
    int n;
    bq.push_back(m_write(a, d, s));
    fork
      begin
        if (mode == 2) begin repeat (gap) @(posedge clk); #1; end
        send_aw(a);
      end
      begin
        if (mode == 1) begin repeat (gap) @(posedge clk); #1; end
        send_w(d, s);
      end
    join
    n = 0;
    @(negedge clk);
    while (!SLOT_bvalid && n < 50) begin
      n++;
      @(negedge clk);
    end
    chk("bvalid_seen", 64'(SLOT_bvalid), 64'd1);
    if (bdly >= 0) begin
      repeat (bdly) @(negedge clk);
      @(posedge clk);
      #1 SLOT_bready = 1'b1;
      @(posedge clk);
      #1 SLOT_bready = 1'b0;
    end
  endtask

  task automatic do_read(input logic [63:0] a, input int rdly);
    int n;
    r_exp_t e;
    e.data = m_read(a);
    e.resp = m_in_range(a) ? 2'b00 : OOR;
    rq.push_back(e);
    SLOT_araddr = a;
    SLOT_arvalid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!SLOT_arready && n < 50) begin
      n++;
      @(negedge clk);
    end
    chk("ar_accepted", 64'(SLOT_arready), 64'd1);
    @(posedge clk);
    #1 SLOT_arvalid = 1'b0;
    n = 0;
    @(negedge clk);
    while (!SLOT_rvalid && n < 50) begin
      n++;
      @(negedge clk);
    end
    chk("rvalid_seen", 64'(SLOT_rvalid), 64'd1);
    repeat (rdly) @(negedge clk);
    @(posedge clk);
    #1 SLOT_rready = 1'b1;
    @(posedge clk);
    #1 SLOT_rready = 1'b0;
  endtask

  // Monitor: pops expectations when the DUT presents B or R, and checks holding behaviour.
  initial begin
    b_exp_t be;
    r_exp_t re;
    logic prev_bvalid;
    logic pulse_chk;
    logic r_hold;
    logic [63:0] r_prev_data;
    logic [1:0] r_prev_resp;
    prev_bvalid = 1'b0;
    pulse_chk = 1'b0;
    r_hold = 1'b0;
    r_prev_data = 64'd0;
    r_prev_resp = 2'b00;
    forever begin
      @(negedge clk);
      if (sys_rst !== 1'b0) begin
        pulse_chk = 1'b0;
        r_hold = 1'b0;
      end else begin
        if (SLOT_bvalid && !prev_bvalid) begin
          if (bq.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL unexpected_b: bvalid rose with no write outstanding, bresp=%0b", SLOT_bresp);
          end else begin
            be = bq.pop_front();
            chk("bresp", 64'(SLOT_bresp), 64'(be.resp));
            chk("wr_pulse", 64'(wr_pulse), 64'(be.mask));
            for (int i = 0; i < NR; i++) begin
              chk($sformatf("cfg_reg%0d", i), cfg_regs[64*i +: 64], be.cfg[64*i +: 64]);
            end
          end
          pulse_chk = 1'b1;
        end else if (pulse_chk) begin
          chk("wr_pulse_one_cycle", 64'(wr_pulse), 64'd0);
          pulse_chk = 1'b0;
        end else if (wr_pulse != '0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL stray_wr_pulse: got 0x%h, expected 0x0", wr_pulse);
        end
        if (SLOT_rvalid && r_hold) begin
          chk("rdata_stable", SLOT_rdata, r_prev_data);
          chk("rresp_stable", 64'(SLOT_rresp), 64'(r_prev_resp));
        end
        if (SLOT_rvalid && SLOT_rready) begin
          if (rq.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL unexpected_r: read data 0x%h with no read outstanding", SLOT_rdata);
          end else begin
            re = rq.pop_front();
            chk("rdata", SLOT_rdata, re.data);
            chk("rresp", 64'(SLOT_rresp), 64'(re.resp));
          end
        end
        r_hold = SLOT_rvalid && !SLOT_rready;
        r_prev_data = SLOT_rdata;
        r_prev_resp = SLOT_rresp;
      end
      prev_bvalid = (SLOT_bvalid === 1'b1);
    end
  end

  // Stimulus: directed scenarios first, then a randomised mix.
  initial begin
    logic [63:0] a;
    sys_rst = 1'b1;
    SLOT_awaddr = 64'd0;
    SLOT_awprot = 3'd0;
    SLOT_awvalid = 1'b0;
    SLOT_wdata = 64'd0;
    SLOT_wstrb = 8'd0;
    SLOT_wvalid = 1'b0;
    SLOT_bready = 1'b0;
    SLOT_araddr = 64'd0;
    SLOT_arprot = 3'd0;
    SLOT_arvalid = 1'b0;
    SLOT_rready = 1'b0;
    status_in = STAT;
    for (int i = 0; i < NR; i++) mregs[i] = 64'd0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_awready", 64'(SLOT_awready), 64'd0);
    chk("rst_wready", 64'(SLOT_wready), 64'd0);
    chk("rst_arready", 64'(SLOT_arready), 64'd0);
    @(posedge clk);
    #1 sys_rst = 1'b0;
    @(negedge clk);
    chk("rel_awready", 64'(SLOT_awready), 64'd1);
    chk("rel_wready", 64'(SLOT_wready), 64'd1);
    chk("rel_arready", 64'(SLOT_arready), 64'd1);
    chk("rel_bvalid", 64'(SLOT_bvalid), 64'd0);
    chk("rel_rvalid", 64'(SLOT_rvalid), 64'd0);
    chk("rel_rdata", SLOT_rdata, 64'd0);
    chk("rel_cfg", cfg_regs[NR*64-1:128], '0);
    @(posedge clk);
    #1;

    do_write(BASE + 64'h10, 64'hDEAD_BEEF_0123_4567, 8'hFF, 0, 0, 1);
    do_write(BASE + 64'h10, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 0, 0, 0);
    do_write(BASE + 64'h10, 64'h0, 8'h0F, 2, 3, 0);
    chk("strb_merge_reg2", cfg_regs[191:128], 64'hFFFF_FFFF_0000_0000);
    do_write(BASE + 64'h18, 64'h1234, 8'h00, 1, 2, 0);
    do_write(BASE + 64'h00, 64'h5555, 8'hFF, 0, 0, 0);
    do_write(BASE + 64'h0C, 64'h7777, 8'hFF, 0, 0, 0);

    do_read(BASE + 64'h0, 5);
    do_read(BASE + 64'h8, 5);
    do_read(BASE + 64'(NR * 8), 2);
    do_read(BASE - 64'h8, 0);
    do_write(BASE + 64'(NR * 8), 64'hA5A5_A5A5_A5A5_A5A5, 8'hFF, 0, 0, 0);

    // Same-edge AR handshake and write commit to register 3.
    do_write(BASE + 64'h18, 64'h1, 8'hFF, 0, 0, 0);
    rq.push_back('{data: m_read(BASE + 64'h18), resp: 2'b00});
    bq.push_back(m_write(BASE + 64'h18, 64'h2, 8'hFF));
    SLOT_awaddr = BASE + 64'h18;
    SLOT_wdata = 64'h2;
    SLOT_wstrb = 8'hFF;
    SLOT_awvalid = 1'b1;
    SLOT_wvalid = 1'b1;
    @(negedge clk);
    chk("same_edge_aw_w_ready", 64'(SLOT_awready & SLOT_wready), 64'd1);
    @(posedge clk);
    #1;
    SLOT_awvalid = 1'b0;
    SLOT_wvalid = 1'b0;
    SLOT_araddr = BASE + 64'h18;
    SLOT_arvalid = 1'b1;
    @(negedge clk);
    chk("same_edge_arready", 64'(SLOT_arready), 64'd1);
    @(posedge clk);
    #1;
    SLOT_arvalid = 1'b0;
    SLOT_bready = 1'b1;
    SLOT_rready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    SLOT_bready = 1'b0;
    SLOT_rready = 1'b0;
    do_read(BASE + 64'h18, 0);

    // Reset while a write response is pending.
    do_write(BASE + 64'h28, 64'hCAFE_F00D_1111_2222, 8'hFF, 0, 0, -1);
    @(posedge clk);
    #1 sys_rst = 1'b1;
    @(negedge clk);
    chk("midrst_awready", 64'(SLOT_awready), 64'd0);
    chk("midrst_arready", 64'(SLOT_arready), 64'd0);
    @(posedge clk);
    #1 sys_rst = 1'b0;
    for (int i = 0; i < NR; i++) mregs[i] = 64'd0;
    @(negedge clk);
    chk("midrst_bvalid", 64'(SLOT_bvalid), 64'd0);
    chk("midrst_reg5", cfg_regs[64*5 +: 64], 64'd0);
    chk("midrst_reg2", cfg_regs[64*2 +: 64], 64'd0);
    chk("midrst_awready_rel", 64'(SLOT_awready), 64'd1);
    repeat (5) @(posedge clk);
    #1;
    do_write(BASE + 64'h28, 64'h0BAD_C0DE_0000_0005, 8'hFF, 0, 0, 0);

    for (int it = 0; it < 60; it++) begin
      if ($urandom_range(0, 9) == 0) begin
        a = ($urandom_range(0, 1) == 0) ? BASE + 64'(NR * 8) + 64'($urandom_range(0, 15)) * 64'd8
                                        : BASE - 64'($urandom_range(1, 64));
      end else begin
        a = BASE + 64'($urandom_range(0, NR - 1)) * 64'd8 + 64'($urandom_range(0, 7));
      end
      if ($urandom_range(0, 2) == 0) begin
        do_read(a, int'($urandom_range(0, 3)));
      end else begin
        do_write(a, {$urandom(), $urandom()}, 8'($urandom_range(0, 255)),
                 int'($urandom_range(0, 2)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
      end
    end

    repeat (5) @(posedge clk);
    chk("b_queue_drained", 64'(bq.size()), 64'd0);
    chk("r_queue_drained", 64'(rq.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
